// File: rtl/gen_tbox_pkg.sv
// gen_tbox_pkg: shared encodings, state/direction enums and cell addressing for the tic-tac-toe box
package gen_tbox_pkg;
    localparam logic [1:0] GS_ON   = 2'b00;
    localparam logic [1:0] GS_XWIN = 2'b01;
    localparam logic [1:0] GS_OWIN = 2'b10;
    localparam logic [1:0] GS_DRAW = 2'b11;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    typedef enum logic [1:0] {DIR_ROW, DIR_COL, DIR_DIAG, DIR_ANTI} dir_t;
    function automatic int cell_idx(input int n, input int r, input int c);
        return (r - 1) * n + (c - 1);
    endfunction
endpackage

// File: rtl/gen_tbox_scan.sv
// gen_tbox_scan: walks a (2K-1)-cell window through the placed cell in four directions and flags a K-run
module gen_tbox_scan
    import gen_tbox_pkg::*;
#(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int CW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [CW-1:0]   row,
    input  logic [CW-1:0]   col,
    input  logic            sym,
    input  logic [N*N-1:0]  valid,
    input  logic [N*N-1:0]  symbol,
    output logic            win,
    output logic            done
);
    localparam int SW  = CW + 2;
    localparam int IW  = $clog2(N * N);
    localparam int SCW = $clog2(2 * K - 1);
    localparam int RW  = $clog2(2 * K);
    dir_t               dir;
    logic               busy;
    logic               psym;
    logic [CW-1:0]      r0;
    logic [CW-1:0]      c0;
    logic [SCW-1:0]     s;
    logic [RW-1:0]      run;
    logic [RW-1:0]      run_n;
    logic signed [SW-1:0] off;
    logic signed [SW-1:0] pr;
    logic signed [SW-1:0] pc;
    logic [IW-1:0]      idx;
    logic               hit;
    // Probe coordinates are signed so cells past any edge fail the bounds test instead of wrapping
    always_comb begin
        off   = SW'(s) - SW'(K - 1);
        pr    = dir == DIR_ROW ? SW'(r0) : SW'(r0) + off;
        pc    = dir == DIR_COL ? SW'(c0) : dir == DIR_ANTI ? SW'(c0) - off : SW'(c0) + off;
        idx   = IW'(cell_idx(N, int'(pr) + 1, int'(pc) + 1));
        hit   = !pr[SW-1] && !pc[SW-1] && pr < $signed(SW'(N)) && pc < $signed(SW'(N))
                && valid[idx] && symbol[idx] == psym;
        run_n = hit ? run + RW'(1) : '0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            dir  <= DIR_ROW;
            s    <= '0;
            run  <= '0;
            win  <= 1'b0;
            done <= 1'b0;
            psym <= 1'b0;
            r0   <= '0;
            c0   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy <= 1'b1;
                dir  <= DIR_ROW;
                s    <= '0;
                run  <= '0;
                win  <= 1'b0;
                psym <= sym;
                r0   <= row - CW'(1);
                c0   <= col - CW'(1);
            end else if (busy) begin
                if (run_n == RW'(K))
                    win <= 1'b1;
                if (s == SCW'(2 * K - 2)) begin
                    s    <= '0;
                    run  <= '0;
                    dir  <= dir_t'(dir + 2'd1);
                    busy <= dir != DIR_ANTI;
                    done <= dir == DIR_ANTI;
                end else begin
                    s   <= s + SCW'(1);
                    run <= run_n;
                end
            end
        end
    end
endmodule

// File: rtl/gen_tbox.sv
// gen_tbox: N x N K-in-a-row game box holding the board, turn, move count and move-evaluation FSM
module gen_tbox
    import gen_tbox_pkg::*;
#(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int CW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set,
    input  logic [CW-1:0]   row,
    input  logic [CW-1:0]   col,
    output logic            ready,
    output logic            move_ok,
    output logic            move_err,
    output logic [N*N-1:0]  valid,
    output logic [N*N-1:0]  symbol,
    output logic [1:0]      game_state,
    output logic            turn
);
    localparam int IW = $clog2(N * N);
    localparam int MW = $clog2(N * N + 1);
    state_t         state;
    logic [MW-1:0]  moves;
    logic [IW-1:0]  idx;
    logic           legal;
    logic           accept;
    logic           win;
    logic           scan_done;
    assign ready = state == IDLE;
    always_comb begin
        idx    = IW'(cell_idx(N, int'(row), int'(col)));
        legal  = row != '0 && col != '0 && row <= CW'(N) && col <= CW'(N);
        accept = set && ready && game_state == GS_ON && legal && !valid[idx];
    end
    gen_tbox_scan #(.N(N), .K(K), .CW(CW)) u_scan (
        .clk    (clk),
        .reset  (reset),
        .start  (accept),
        .row    (row),
        .col    (col),
        .sym    (turn),
        .valid  (valid),
        .symbol (symbol),
        .win    (win),
        .done   (scan_done)
    );
    // turn has already flipped during SCAN, so the placed symbol is ~turn
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            valid      <= '0;
            symbol     <= '0;
            game_state <= GS_ON;
            turn       <= 1'b1;
            moves      <= '0;
            move_ok    <= 1'b0;
            move_err   <= 1'b0;
        end else begin
            move_ok  <= 1'b0;
            move_err <= 1'b0;
            if (accept) begin
                valid[idx]  <= 1'b1;
                symbol[idx] <= turn;
                turn        <= ~turn;
                moves       <= moves + MW'(1);
                state       <= SCAN;
            end else if (ready && set) begin
                move_err <= 1'b1;
            end else if (state == SCAN && scan_done) begin
                state      <= DONE;
                move_ok    <= 1'b1;
                game_state <= win ? (turn ? GS_OWIN : GS_XWIN) : moves == MW'(N * N) ? GS_DRAW : GS_ON;
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: doc/gen_tbox.md
GEN_TBOX -- requirements
Module: gen_tbox

Interface
REQ-001 Parameter N, default 3: board side, legal range 3..8.
REQ-002 Parameter K, default 3: win run length, legal range 3..N.
REQ-003 Parameter CW, default $clog2(N+1): row/col index width.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 set  in  1  move request, sampled only when ready=1.
REQ-007 row  in  CW  1-based row of move, legal 1..N.
REQ-008 col  in  CW  1-based column of move, legal 1..N.
REQ-009 ready  out  1  high when a move can be accepted.
REQ-010 move_ok  out  1  one-cycle pulse when an accepted move's evaluation completes.
REQ-011 move_err  out  1  one-cycle pulse, asserted the cycle after a rejected move.
REQ-012 valid  out  N*N  occupied flag per cell; cell index = (row-1)*N + (col-1).
REQ-013 symbol  out  N*N  per-cell owner, 1=X, 0=O; meaningful only where valid=1.
REQ-014 game_state  out  2  00 on, 01 X won, 10 O won, 11 draw.
REQ-015 turn  out  1  next player, 1=X, 0=O.

Function
REQ-016 FSM states: IDLE, SCAN, DONE; ready=1 only in IDLE.
REQ-017 Rejected move, IDLE with set=1: game_state!=00, row or col equal to 0 or greater than N, or target cell valid=1.
- Rejection pulses move_err next cycle and stays in IDLE.
- Board, turn and move count are unchanged.
REQ-018 Accepted move at edge E0:
- valid[idx]=1 and symbol[idx]=turn, visible after E0.
- turn toggles; move count increments.
- FSM enters SCAN.
REQ-019 SCAN evaluates four directions in order: row, column, diagonal (+1,+1), antidiagonal (+1,-1).
- Per direction, step s runs -(K-1)..K-1, one cell per cycle, total 4*(2K-1) cycles, no early exit.
REQ-020 Run counter:
- Clears at each direction start.
- Increments when the probed cell is on-board, valid, and matches the placed symbol.
- Otherwise clears.
- win flag sets when the counter reaches K.
REQ-021 Off-board probe coordinates count as mismatches, computed at CW+2 signed width, with no wrap-around between rows.
REQ-022 DONE lasts one cycle:
- game_state = 01/10 per placed symbol if win.
- Else 11 if move count == N*N.
- Else 00.
- move_ok pulses; next state IDLE.
REQ-023 Fixed latency: game_state and move_ok valid exactly 4*(2K-1)+1 cycles after E0; ready returns on the following cycle.
REQ-024 set while ready=0 is ignored, with no move_err and no side effects.
REQ-025 A win on the final cell reports 01/10, not 11; win has priority over draw.
REQ-026 Once game_state!=00 it holds until reset; all further moves are rejected per REQ-017.

Reset
REQ-027 reset=0 asynchronously forces, without waiting for clk, including mid-SCAN:
- valid=0, symbol=0, game_state=00, turn=1.
- move count 0, FSM IDLE, move_ok=0, move_err=0.
REQ-028 ready=1 from the first cycle after reset deasserts.

Structure
REQ-029 Package gen_tbox_pkg holds the game_state encodings (GS_ON, GS_XWIN, GS_OWIN, GS_DRAW), the FSM state enum, the direction enum, and the cell-index function.
REQ-030 Sub-module gen_tbox_scan contains the direction/step counters, probe address generation, run counter and win flag; gen_tbox holds the board, turn, move count, FSM and outputs.

Verification
REQ-031 Reset, N=3: after reset release, valid=0, game_state=00, ready=1, turn=1.
REQ-032 N=3, K=3 row win: moves X(1,1) O(2,1) X(1,2) O(2,2) X(1,3).
- game_state=01 and move_ok exactly 21 cycles after the last accept.
- Next set gives move_err; board unchanged.
REQ-033 N=3 draw: moves (1,1)(1,2)(1,3)(2,1)(2,3)(2,2)(3,2)(3,3)(3,1).
- game_state=00 after each of the first 8 moves; 11 after the 9th.
REQ-034 N=5, K=4 antidiagonal: moves X(1,1) O(1,5) X(1,2) O(2,4) X(1,3) O(3,3) X(5,5) O(4,2).
- game_state=10 after 29 cycles; 00 after every earlier move, X's 3-run included.
REQ-035 Illegal moves: occupied (1,1), row=0, col=N+1, each in turn.
- Each pulses move_err one cycle later; turn, valid and move count unchanged.
REQ-036 reset=0 asserted 5 cycles into SCAN: all outputs reach reset values before the next clk edge; FSM is IDLE after release.
